tl_fragmenter_client_arbiter: RTL

// - Shares the single TileLink A/D port of the fragmenter wrapper (A: Get-only, no A data; D: size/source/data)

---
 rtl/tl_fragmenter_client_arbiter_pkg.sv | 21 ++
 rtl/tl_fragmenter_client_arbiter_rr_arbiter.sv | 50 +++++
 rtl/tl_fragmenter_client_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tl_fragmenter_client_arbiter_pkg.sv
// Shared definitions for the fragmenter client arbiter.
//   - TileLink A opcode constant for Get (the only A message this port carries)
//   - beat geometry (8-byte beats) and the manager-side source width
//   - beats_from_size(): number of D beats a response of a given size spans
package tl_frag_arb_pkg;

  localparam logic [2:0] OP_GET          = 3'd4;
  localparam int         BEAT_BYTES_LOG2 = 3;
  // Manager source = {client index tag, client source}.
  localparam int         MGR_SRC_W       = 3;
  // Wide enough for the largest TileLink size (2^7 bytes = 16 beats).
  localparam int         BEATS_W         = 5;

  function automatic logic [BEATS_W-1:0] beats_from_size(input logic [2:0] size);
    if (size <= 3'(BEAT_BYTES_LOG2)) begin
      return 5'd1;
    end
    return 5'd1 << (size - 3'(BEAT_BYTES_LOG2));
  endfunction

endpackage

// File: rtl/tl_fragmenter_client_arbiter_rr_arbiter.sv
// N-way round-robin arbiter with eligibility mask and grant lock.
//   req_i        per-requester request (used only for the locked requester)
//   elig_i       per-requester eligibility for the round-robin scan
//   ptr_i        highest-priority index for this cycle's scan
//   lock_i       when set, grant is forced to lock_idx_i
//   lock_idx_i   requester held by the lock
//   grant_oh_o   one-hot grant
//   grant_idx_o  binary grant index (0 when nothing granted)
//   grant_vld_o  a grant exists this cycle
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             lock_i,
  input  logic [IDX_W-1:0] lock_idx_i,
  output logic [N-1:0]     grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_vld_o = 1'b0;
    grant_idx_o = '0;
    cand        = '0;
    if (lock_i) begin
      // The locked requester already passed eligibility when the lock formed.
      grant_vld_o = req_i[lock_idx_i];
      grant_idx_o = lock_idx_i;
    end else begin
      for (int k = 0; k < N; k++) begin
        // N is a power of two, so the IDX_W-bit add wraps modulo N.
        cand = ptr_i + IDX_W'(k);
        if (!grant_vld_o && elig_i[cand]) begin
          grant_vld_o = 1'b1;
          grant_idx_o = cand;
        end
      end
    end
    grant_oh_o = '0;
    if (grant_vld_o) begin
      grant_oh_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/tl_fragmenter_client_arbiter.sv
// Shares one TileLink Get-only A / D port among NUM_CLIENTS masters.
//   clock, reset         single clock, synchronous active-high reset
//   c_a_*                per-client A channel (packed, client i at slice i)
//   c_d_valid/c_d_ready  per-client D handshake; c_d_size/source/data broadcast
//   m_a_*                A channel towards the fragmenter, source tagged with client index
//   m_d_*                D channel from the fragmenter, routed by source tag
module tl_fragmenter_client_arbiter
  import tl_frag_arb_pkg::*;
#(
  parameter int NUM_CLIENTS     = 2,
  parameter int CLIENT_SRC_W    = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 17,
  parameter int DATA_W          = 64
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_CLIENTS-1:0]              c_a_valid,
  output logic [NUM_CLIENTS-1:0]              c_a_ready,
  input  logic [NUM_CLIENTS*3-1:0]            c_a_opcode,
  input  logic [NUM_CLIENTS*3-1:0]            c_a_param,
  input  logic [NUM_CLIENTS*3-1:0]            c_a_size,
  input  logic [NUM_CLIENTS*CLIENT_SRC_W-1:0] c_a_source,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]       c_a_address,
  input  logic [NUM_CLIENTS*8-1:0]            c_a_mask,
  input  logic [NUM_CLIENTS-1:0]              c_a_corrupt,
  output logic [NUM_CLIENTS-1:0]              c_d_valid,
  input  logic [NUM_CLIENTS-1:0]              c_d_ready,
  output logic [2:0]                          c_d_size,
  output logic [CLIENT_SRC_W-1:0]             c_d_source,
  output logic [DATA_W-1:0]                   c_d_data,
  output logic                                m_a_valid,
  input  logic                                m_a_ready,
  output logic [2:0]                          m_a_opcode,
  output logic [2:0]                          m_a_param,
  output logic [2:0]                          m_a_size,
  output logic [MGR_SRC_W-1:0]                m_a_source,
  output logic [ADDR_W-1:0]                   m_a_address,
  output logic [7:0]                          m_a_mask,
  output logic                                m_a_corrupt,
  input  logic                                m_d_valid,
  output logic                                m_d_ready,
  input  logic [2:0]                          m_d_size,
  input  logic [MGR_SRC_W-1:0]                m_d_source,
  input  logic [DATA_W-1:0]                   m_d_data
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic                               lock_q, lock_d;
  logic [IDX_W-1:0]                   lock_idx_q, lock_idx_d;
  logic [BEATS_W-1:0]                 beats_left_q, beats_left_d;
  logic                               in_d_burst_q, in_d_burst_d;
  logic [NUM_CLIENTS-1:0][CNT_W-1:0]  outstanding_q, outstanding_d;

  logic [NUM_CLIENTS-1:0] elig, grant_oh, cnt_inc, cnt_dec;
  logic [IDX_W-1:0]       grant_idx, d_idx;
  logic                   grant_vld, a_fire, d_fire, d_last;
  logic [BEATS_W-1:0]     d_beats;

  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      assign elig[gi]      = c_a_valid[gi] && (outstanding_q[gi] < CNT_W'(MAX_OUTSTANDING));
      assign c_a_ready[gi] = !reset && m_a_ready && grant_oh[gi];
      assign c_d_valid[gi] = !reset && m_d_valid && (d_idx == IDX_W'(gi));
      assign cnt_inc[gi]   = a_fire && (grant_idx == IDX_W'(gi));
      assign cnt_dec[gi]   = d_fire && d_last && (d_idx == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_rr (
    .req_i       (c_a_valid),
    .elig_i      (elig),
    .ptr_i       (rr_ptr_q),
    .lock_i      (lock_q),
    .lock_idx_i  (lock_idx_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  // A path: pure mux of the granted client, zero latency.
  assign m_a_valid   = !reset && grant_vld;
  assign m_a_opcode  = c_a_opcode[grant_idx*3 +: 3];
  assign m_a_param   = c_a_param[grant_idx*3 +: 3];
  assign m_a_size    = c_a_size[grant_idx*3 +: 3];
  assign m_a_source  = {grant_idx, c_a_source[grant_idx*CLIENT_SRC_W +: CLIENT_SRC_W]};
  assign m_a_address = c_a_address[grant_idx*ADDR_W +: ADDR_W];
  assign m_a_mask    = c_a_mask[grant_idx*8 +: 8];
  assign m_a_corrupt = c_a_corrupt[grant_idx];
  assign a_fire      = m_a_valid && m_a_ready;

  // D path: route by the tag bits at the top of the manager source.
  assign d_idx      = m_d_source[MGR_SRC_W-1 -: IDX_W];
  assign m_d_ready  = !reset && c_d_ready[d_idx];
  assign c_d_size   = m_d_size;
  assign c_d_source = m_d_source[CLIENT_SRC_W-1:0];
  assign c_d_data   = m_d_data;
  assign d_fire     = m_d_valid && m_d_ready;
  assign d_beats    = beats_from_size(m_d_size);
  assign d_last     = in_d_burst_q ? (beats_left_q == '0) : (d_beats == 5'd1);

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_idx_d   = lock_idx_q;
    beats_left_d = beats_left_q;
    in_d_burst_d = in_d_burst_q;

    if (a_fire) begin
      rr_ptr_d = grant_idx + IDX_W'(1);
      lock_d   = 1'b0;
    end else if (m_a_valid) begin
      // Stalled offer: hold the same client until it fires.
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end

    if (d_fire) begin
      if (!in_d_burst_q) begin
        if (d_beats != 5'd1) begin
          beats_left_d = d_beats - 5'd2;
          in_d_burst_d = 1'b1;
        end
      end else if (beats_left_q == '0) begin
        in_d_burst_d = 1'b0;
      end else begin
        beats_left_d = beats_left_q - 5'd1;
      end
    end

    outstanding_d = outstanding_q;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      case ({cnt_inc[i], cnt_dec[i]})
        2'b10:   outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
        2'b01:   outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
        default: outstanding_d[i] = outstanding_q[i];
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      lock_idx_q    <= '0;
      beats_left_q  <= '0;
      in_d_burst_q  <= 1'b0;
      outstanding_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      lock_idx_q    <= lock_idx_d;
      beats_left_q  <= beats_left_d;
      in_d_burst_q  <= in_d_burst_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule
